// File: rtl/fetch_prefetch_stage.sv
// IF stage: owns the fetch PC, issues one word read per cycle against credit, and buffers responses in a prefetch FIFO.
// Optional build macro FETCH_BYPASS_EN: forward an arriving response straight to decode when the FIFO is empty.
module fetch_prefetch_stage #(
    parameter int               ISIZE    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ISIZE-1:0] RESET_PC = {ISIZE{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ISIZE-1:0]         imem_addr,
    input  logic [ISIZE-1:0]         imem_rdata,
    input  logic                     id_stall,
    input  logic                     redirect,
    input  logic [ISIZE-1:0]         redirect_pc,
    output logic [ISIZE-1:0]         inst_out,
    output logic [ISIZE-1:0]         pc_out,
    output logic                     inst_valid,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    logic [ISIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic             inflight_q, inflight_d;
    logic [ISIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic [ISIZE-1:0] fifo_inst_q [DEPTH];
    logic [ISIZE-1:0] fifo_inst_d [DEPTH];
    logic [ISIZE-1:0] fifo_pc_q   [DEPTH];
    logic [ISIZE-1:0] fifo_pc_d   [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [CW:0]      credit_s;
    logic             issue_s;
    logic             empty_s;
    logic             byp_s;
    logic             byp_take_s;
    logic             push_s;
    logic             pop_s;

    // Issue credit, bypass detection and FIFO push/pop qualification
    always_comb begin
        credit_s   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue_s    = !redirect && (credit_s < DEPTH_C);
        empty_s    = (count_q == {CW{1'b0}});
`ifdef FETCH_BYPASS_EN
        byp_s      = empty_s && inflight_q && !redirect;
`else
        byp_s      = 1'b0;
`endif
        byp_take_s = byp_s && !id_stall;
        // A bypassed response that decode consumes is never written into the FIFO.
        push_s     = inflight_q && !redirect && !byp_take_s;
        pop_s      = !empty_s && !id_stall && !redirect;
    end

    // Next-state for fetch PC, in-flight tracking and FIFO storage
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fifo_inst_d   = fifo_inst_q;
        fifo_pc_d     = fifo_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            if (issue_s) begin
                fetch_pc_d    = fetch_pc_q + ISIZE'(1'b1);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end else begin
                inflight_d    = 1'b0;
            end
            if (push_s) begin
                fifo_inst_d[wr_ptr_q] = imem_rdata;
                fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d              = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d              = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= {ISIZE{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            wr_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= {ISIZE{1'b0}};
                fifo_pc_q[i]   <= {ISIZE{1'b0}};
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_inst_q[i] <= fifo_inst_d[i];
                fifo_pc_q[i]   <= fifo_pc_d[i];
            end
        end
    end

    // Head presentation: FIFO head, else bypassed response, else zeros
    always_comb begin
        imem_addr  = fetch_pc_q;
        fifo_count = count_q;
        inst_valid = !empty_s || byp_s;
        if (!empty_s) begin
            inst_out = fifo_inst_q[rd_ptr_q];
            pc_out   = fifo_pc_q[rd_ptr_q];
        end else if (byp_s) begin
            inst_out = imem_rdata;
            pc_out   = inflight_pc_q;
        end else begin
            inst_out = {ISIZE{1'b0}};
            pc_out   = {ISIZE{1'b0}};
        end
    end

endmodule

// File: doc/fetch_prefetch_stage.md
Name: fetch_prefetch_stage

Overview:
- IF stage that sits directly upstream of the decode/register-read stage and the ID/EXE pipeline register; replaces a bare PC + instruction-memory pair.
- Owns the fetch PC and drives the word-addressed instruction memory, which returns data one clock after the address.
- Buffers returned instructions in a small FIFO so decode can stall without losing in-flight reads.
- Supports a redirect (branch/jump) that flushes all fetched-but-unconsumed instructions.

Parameters:
- ISIZE, 32, instruction and PC width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  ISIZE  instruction-memory word address; always equals fetch_pc.
- imem_rdata  input  ISIZE  instruction data; valid one cycle after the address was presented.
- id_stall  input  1  decode cannot accept this cycle.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  ISIZE  new fetch PC, sampled when redirect=1.
- inst_out  output  ISIZE  instruction at the FIFO head; 0 when inst_valid=0.
- pc_out  output  ISIZE  PC of inst_out; 0 when inst_valid=0.
- inst_valid  output  1  FIFO non-empty.
- fifo_count  output  log2(DEPTH)+1  current occupancy, for debug.

Behaviour:
- Reset is asynchronous, active-high, one clock (clk).
- Reset state: fetch_pc=RESET_PC, inflight=0, FIFO empty, count=0, inst_valid=0, inst_out=0, pc_out=0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- issue = !redirect && (count + inflight < DEPTH).
- On a clock edge with issue=1:
  - fetch_pc <= fetch_pc+1 (word increment, wraps modulo 2^ISIZE).
  - inflight <= 1; inflight_pc <= fetch_pc.
- On a clock edge with issue=0: fetch_pc holds and inflight <= 0.
- Response: when inflight=1 at an edge, push {imem_rdata, inflight_pc} into the FIFO.
- Pop = inst_valid && !id_stall.
- Push and pop on the same edge: count is unchanged and ordering is preserved.
- Push into a full FIFO cannot occur because of the issue credit rule. The bench asserts this as an illegal state.
- Latency: an address issued at edge N delivers data at edge N+1; the instruction appears at the head after edge N+1, i.e. 2 cycles from issue to inst_valid.
- After reset with no stall, inst_valid rises in the 2nd cycle after reset release. Throughput is then 1 instruction per cycle.
- Redirect (priority over everything) on an edge:
  - FIFO is emptied (count=0) and any pop that cycle is ignored.
  - inflight <= 0, so the response arriving next cycle is discarded.
  - fetch_pc <= redirect_pc.
  - Issuing resumes on the following cycle.
- Redirect with rst asserted: rst wins.
- Back-to-back redirects: each one restarts fetch; only the last redirect_pc is fetched.
- id_stall has no effect on fetch directly. Fetch stops only by credit exhaustion, and resumes the cycle after a pop frees a slot.
- FIFO pointers are log2(DEPTH) bits and wrap naturally; count is tracked separately to distinguish full from empty.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and a response is arriving (inflight=1, no redirect), imem_rdata and inflight_pc drive inst_out/pc_out combinationally with inst_valid=1.
  - If popped that cycle (id_stall=0), the entry is not written.
  - If stalled, it is written normally.
  - Issue-to-valid latency becomes 1 cycle.
- Undefined: outputs come only from FIFO registers, and latency is 2 cycles as specified above.

Test Plan:
- Reset release, memory word k = 0x1000+k, no stall: inst_valid rises 2 cycles after release; heads are pc 0,1,2,3 with 0x1000..0x1003 on consecutive cycles.
- Hold id_stall=1 for 10 cycles: fifo_count saturates at 4 and fetch_pc stops at 4. Release: pcs 0..7 emerge in order with no gap or duplicate.
- Redirect to 0x40 while count=3 and inflight=1: next cycle inst_valid=0 and the stale response is dropped; two cycles later the head is pc 0x40 with mem[0x40].
- Redirect and pop in the same cycle with the head at pc 5: pc 5 is not consumed twice; the next valid pc is redirect_pc.
- Assert rst mid-stream with count=2: all outputs are 0 immediately (before the next edge); after release, fetch restarts at RESET_PC.
- With FETCH_BYPASS_EN, no stall: inst_valid rises 1 cycle after reset release, pc 0 = 0x1000, and fifo_count stays 0.
